// File: rtl/instruktion_lader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : instruktion_lader
//  Purpose  : UART boot loader. Holds the CPU in reset, receives a program
//             image (16-bit word count, then little-endian 32-bit words) and
//             writes it word by word through the instruction-cache write port.
//  Revision : 1.0  initial release
// ============================================================================
module instruktion_lader #(
    parameter int CLOCKHZ    = 5000000,
    parameter int BAUD       = 115200,
    parameter int ADRESSBITS = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Rx,
    input  logic        DatenGeschrieben,
    output logic        Schreiben,
    output logic [31:0] Adresse,
    output logic [31:0] Daten,
    output logic        Initialisierung,
    output logic        CPUReset,
    output logic        Fertig,
    output logic        Fehler
);

    localparam int TEILER = CLOCKHZ / BAUD;
    localparam int HALB   = TEILER / 2;
    localparam int CW     = $clog2(TEILER + 1);
    // one extra bit so the address can reach 2**ADRESSBITS after the last ack
    localparam int AW     = ADRESSBITS + 1;

    localparam logic [CW-1:0] C_BIT_ENDE   = CW'(TEILER - 1);
    localparam logic [CW-1:0] C_HALB_ENDE  = CW'(HALB - 1);
    localparam logic [16:0]   C_MAX_WORTE  = 17'(2 ** ADRESSBITS);

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_RUHE  = 2'd0,
        RX_START = 2'd1,
        RX_DATEN = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t       rx_state_q, rx_state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_sync_q, rx_sync_d;
    logic            rx_prev_q, rx_prev_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            byte_ok_q, byte_ok_d;
    logic            rahmen_fehler_q, rahmen_fehler_d;

    // receiver next state: synchroniser, start detection, bit sampling
    always_comb begin
        rx_meta_d       = Rx;
        rx_sync_d       = rx_meta_q;
        rx_prev_d       = rx_sync_q;
        rx_state_d      = rx_state_q;
        cnt_d           = cnt_q + CW'(1);
        bit_d           = bit_q;
        rx_byte_d       = rx_byte_q;
        byte_ok_d       = 1'b0;
        rahmen_fehler_d = 1'b0;
        unique case (rx_state_q)
            RX_RUHE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // mid-start-bit check; a high line here means it was a glitch
                if (cnt_q == C_HALB_ENDE) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    rx_state_d = rx_sync_q ? RX_RUHE : RX_DATEN;
                end
            end
            RX_DATEN: begin
                if (cnt_q == C_BIT_ENDE) begin
                    cnt_d     = '0;
                    rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
                    bit_d     = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == C_BIT_ENDE) begin
                    cnt_d           = '0;
                    rx_state_d      = RX_RUHE;
                    byte_ok_d       = rx_sync_q;
                    rahmen_fehler_d = !rx_sync_q;
                end
            end
        endcase
    end

    // receiver state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_state_q      <= RX_RUHE;
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            rx_prev_q       <= 1'b1;
            cnt_q           <= '0;
            bit_q           <= 3'd0;
            rx_byte_q       <= 8'h00;
            byte_ok_q       <= 1'b0;
            rahmen_fehler_q <= 1'b0;
        end else begin
            rx_state_q      <= rx_state_d;
            rx_meta_q       <= rx_meta_d;
            rx_sync_q       <= rx_sync_d;
            rx_prev_q       <= rx_prev_d;
            cnt_q           <= cnt_d;
            bit_q           <= bit_d;
            rx_byte_q       <= rx_byte_d;
            byte_ok_q       <= byte_ok_d;
            rahmen_fehler_q <= rahmen_fehler_d;
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM and write port
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        LAENGE0  = 3'd0,
        LAENGE1  = 3'd1,
        EMPFANGE = 3'd2,
        FERTIG   = 3'd3,
        FEHLER   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [AW-1:0]   len_q, len_d;
    logic [31:0]     asm_q, asm_d;
    logic [1:0]      idx_q, idx_d;
    logic            wort_fertig_q, wort_fertig_d;
    logic [31:0]     wbuf_q, wbuf_d;
    logic            schr_q, schr_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [AW-1:0]   nrx_q, nrx_d;
    logic [16:0]     laenge_neu;
    logic [AW-1:0]   adr_plus;

    // loader next state: length decode, word assembly, write handshake
    always_comb begin
        state_d       = state_q;
        len_lo_d      = len_lo_q;
        len_d         = len_q;
        asm_d         = asm_q;
        idx_d         = idx_q;
        wort_fertig_d = 1'b0;
        wbuf_d        = wbuf_q;
        schr_d        = schr_q;
        adr_d         = adr_q;
        nrx_d         = nrx_q;
        laenge_neu    = {1'b0, rx_byte_q, len_lo_q};
        adr_plus      = adr_q + AW'(1);
        case (state_q)
            LAENGE0: begin
                if (rahmen_fehler_q) begin
                    state_d = FEHLER;
                end else if (byte_ok_q) begin
                    len_lo_d = rx_byte_q;
                    state_d  = LAENGE1;
                end
            end
            LAENGE1: begin
                if (rahmen_fehler_q) begin
                    state_d = FEHLER;
                end else if (byte_ok_q) begin
                    len_d = laenge_neu[AW-1:0];
                    if (laenge_neu == 17'd0) begin
                        state_d = FERTIG;
                    end else if (laenge_neu > C_MAX_WORTE) begin
                        state_d = FEHLER;
                    end else begin
                        state_d = EMPFANGE;
                    end
                end
            end
            EMPFANGE: begin
                if (schr_q && DatenGeschrieben) begin
                    schr_d = 1'b0;
                    adr_d  = adr_plus;
                    if (adr_plus == len_q) begin
                        state_d = FERTIG;
                    end
                end
                // a completed word needs a free write buffer, else overflow
                if (wort_fertig_q) begin
                    if (schr_q && !DatenGeschrieben) begin
                        state_d = FEHLER;
                    end else begin
                        wbuf_d = asm_q;
                        schr_d = 1'b1;
                    end
                end
                // bytes beyond the announced image are dropped
                if (byte_ok_q && (nrx_q != len_q)) begin
                    case (idx_q)
                        2'd0:    asm_d[7:0]   = rx_byte_q;
                        2'd1:    asm_d[15:8]  = rx_byte_q;
                        2'd2:    asm_d[23:16] = rx_byte_q;
                        default: asm_d[31:24] = rx_byte_q;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wort_fertig_d = 1'b1;
                        nrx_d         = nrx_q + AW'(1);
                    end
                end
                if (rahmen_fehler_q) begin
                    state_d = FEHLER;
                end
            end
            FERTIG: begin
                state_d = FERTIG;
            end
            FEHLER: begin
                state_d = FEHLER;
            end
            default: begin
                state_d = FEHLER;
            end
        endcase
        if (state_d == FEHLER) begin
            schr_d = 1'b0;
        end
    end

    // loader state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= LAENGE0;
            len_lo_q      <= 8'h00;
            len_q         <= '0;
            asm_q         <= 32'h0;
            idx_q         <= 2'd0;
            wort_fertig_q <= 1'b0;
            wbuf_q        <= 32'h0;
            schr_q        <= 1'b0;
            adr_q         <= '0;
            nrx_q         <= '0;
        end else begin
            state_q       <= state_d;
            len_lo_q      <= len_lo_d;
            len_q         <= len_d;
            asm_q         <= asm_d;
            idx_q         <= idx_d;
            wort_fertig_q <= wort_fertig_d;
            wbuf_q        <= wbuf_d;
            schr_q        <= schr_d;
            adr_q         <= adr_d;
            nrx_q         <= nrx_d;
        end
    end

    // outputs follow the registered state directly
    always_comb begin
        Schreiben       = schr_q;
        Adresse         = {{(32 - AW){1'b0}}, adr_q};
        Daten           = wbuf_q;
        Fertig          = (state_q == FERTIG);
        Fehler          = (state_q == FEHLER);
        Initialisierung = (state_q != FERTIG);
        CPUReset        = (state_q != FERTIG);
    end

endmodule
`default_nettype wire

// File: tb/tb_instruktion_lader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_instruktion_lader
//  Purpose  : Self-checking bench for the UART boot loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruktion_lader;

    localparam int TEILER = 5000000 / 115200;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        dg;
    logic        schreiben;
    logic [31:0] adresse;
    logic [31:0] daten;
    logic        init;
    logic        cpurst;
    logic        fertig;
    logic        fehler;

    int n_cmp = 0;
    int n_err = 0;
    int ack_delay = -1;
    int stab_err = 0;
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];

    instruktion_lader #(.CLOCKHZ(5000000), .BAUD(115200), .ADRESSBITS(8)) dut (
        .Clock(clk), .Reset(rst_n), .Rx(rx), .DatenGeschrieben(dg),
        .Schreiben(schreiben), .Adresse(adresse), .Daten(daten),
        .Initialisierung(init), .CPUReset(cpurst), .Fertig(fertig), .Fehler(fehler)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // cache model: logs each write request, checks it is held, acks after ack_delay cycles
    initial begin : responder
        bit pending;
        int wc;
        logic [31:0] a0, d0;
        pending = 0; wc = 0; a0 = 0; d0 = 0; dg = 1'b0;
        forever begin
            @(negedge clk);
            dg = 1'b0;
            if (!rst_n) begin
                pending = 0;
            end else begin
                if (pending && !schreiben) pending = 0;
                if (!pending && schreiben) begin
                    pending = 1; wc = 0; a0 = adresse; d0 = daten;
                    wr_adr.push_back(adresse);
                    wr_dat.push_back(daten);
                end
                if (pending) begin
                    if (adresse !== a0 || daten !== d0) stab_err++;
                    if (ack_delay >= 0 && wc == ack_delay) dg = 1'b1;
                    wc++;
                end
            end
        end
    end

    task automatic do_reset();
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        wr_adr.delete();
        wr_dat.delete();
        stab_err = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (TEILER) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (TEILER) @(negedge clk);
        end
        rx = stop;
        repeat (TEILER) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (TEILER) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[7:0], 1'b1);
            t = t >> 8;
        end
    endtask

    task automatic wait_status(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (fertig || fehler) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        logic [70:0] got;
        ack_delay = -1;
        do_reset();
        n_cmp++; if ({schreiben, init, cpurst, fertig, fehler} !== 5'b01100) begin n_err++;
            $display("FAIL reset_idle: got %b required 01100", {schreiben, init, cpurst, fertig, fehler}); end
        // dirty the state: pending write plus a half-received byte
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_word(32'hDEADBEEF);
        repeat (4) @(negedge clk);
        n_cmp++; if (schreiben !== 1'b1) begin n_err++;
            $display("FAIL reset_pre_pending: got %b required 1", schreiben); end
        rx = 1'b0;
        repeat (TEILER * 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        got = {schreiben, adresse, daten, init, cpurst, fertig, fehler};
        n_cmp++; if (got !== {1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin n_err++;
            $display("FAIL reset_async_values: got %h required %h", got, {1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0}); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        wr_adr.delete(); wr_dat.delete(); stab_err = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ack_delay = 3;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_word(32'hCAFE0001);
        wait_status(200, ok);
        n_cmp++; if (!ok || fertig !== 1'b1) begin n_err++;
            $display("FAIL reset_reload_done: got fertig=%b required 1", fertig); end
        n_cmp++; if (wr_adr.size() != 1) begin n_err++;
            $display("FAIL reset_reload_count: got %0d required 1", wr_adr.size()); end
        else begin
            n_cmp++; if (wr_adr[0] !== 32'h0 || wr_dat[0] !== 32'hCAFE0001) begin n_err++;
                $display("FAIL reset_reload_write: got (%h,%h) required (0,cafe0001)", wr_adr[0], wr_dat[0]); end
        end
    endtask

    task automatic test_image();
        bit ok;
        logic [7:0] s[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        ack_delay = 3;
        do_reset();
        foreach (s[i]) send_byte(s[i], 1'b1);
        wait_status(200, ok);
        n_cmp++; if (!ok || {fertig, cpurst, init, fehler} !== 4'b1000) begin n_err++;
            $display("FAIL image_status: got fertig/cpurst/init/fehler=%b required 1000", {fertig, cpurst, init, fehler}); end
        n_cmp++; if (wr_adr.size() != 2) begin n_err++;
            $display("FAIL image_count: got %0d required 2", wr_adr.size()); end
        else begin
            n_cmp++; if (wr_adr[0] !== 32'd0 || wr_dat[0] !== 32'h00000013) begin n_err++;
                $display("FAIL image_w0: got (%h,%h) required (0,00000013)", wr_adr[0], wr_dat[0]); end
            n_cmp++; if (wr_adr[1] !== 32'd1 || wr_dat[1] !== 32'h00100093) begin n_err++;
                $display("FAIL image_w1: got (%h,%h) required (1,00100093)", wr_adr[1], wr_dat[1]); end
        end
        n_cmp++; if (adresse !== 32'd2 || stab_err != 0) begin n_err++;
            $display("FAIL image_end_addr: got adr=%0d unstable=%0d required 2/0", adresse, stab_err); end
        send_byte(8'hAA, 1'b1);
        repeat (10) @(negedge clk);
        n_cmp++; if (wr_adr.size() != 2 || fertig !== 1'b1) begin n_err++;
            $display("FAIL image_after_done: got writes=%0d fertig=%b required 2/1", wr_adr.size(), fertig); end
    endtask

    task automatic test_zero_len();
        bit ok;
        ack_delay = 0;
        do_reset();
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        wait_status(50, ok);
        n_cmp++; if (!ok || fertig !== 1'b1 || cpurst !== 1'b0 || wr_adr.size() != 0) begin n_err++;
            $display("FAIL zero_len: got fertig=%b cpurst=%b writes=%0d required 1/0/0", fertig, cpurst, wr_adr.size()); end
    endtask

    task automatic test_framing();
        bit ok;
        ack_delay = 3;
        do_reset();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h55, 1'b0);
        wait_status(50, ok);
        n_cmp++; if (!ok || {fehler, cpurst, init, fertig, schreiben} !== 5'b11100) begin n_err++;
            $display("FAIL framing_status: got %b required 11100", {fehler, cpurst, init, fertig, schreiben}); end
        send_word(32'h12345678);
        repeat (10) @(negedge clk);
        n_cmp++; if (wr_adr.size() != 0 || fehler !== 1'b1) begin n_err++;
            $display("FAIL framing_sticky: got writes=%0d fehler=%b required 0/1", wr_adr.size(), fehler); end
    endtask

    task automatic test_overflow();
        logic [31:0] w0, w1, t;
        w0 = $urandom; w1 = $urandom;
        ack_delay = -1;
        do_reset();
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_word(w0);
        repeat (5) @(negedge clk);
        n_cmp++; if (schreiben !== 1'b1 || adresse !== 32'd0 || daten !== w0) begin n_err++;
            $display("FAIL ovf_w0_pending: got (%b,%h,%h) required (1,0,%h)", schreiben, adresse, daten, w0); end
        t = w1;
        for (int k = 0; k < 3; k++) begin send_byte(t[7:0], 1'b1); t = t >> 8; end
        n_cmp++; if (fehler !== 1'b0 || schreiben !== 1'b1 || adresse !== 32'd0) begin n_err++;
            $display("FAIL ovf_hold: got fehler=%b schr=%b adr=%h required 0/1/0", fehler, schreiben, adresse); end
        send_byte(t[7:0], 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++; if ({fehler, schreiben, cpurst} !== 3'b101 || wr_adr.size() != 1 || stab_err != 0) begin n_err++;
            $display("FAIL ovf_error: got fehler/schr/cpurst=%b writes=%0d required 101/1", {fehler, schreiben, cpurst}, wr_adr.size()); end
    endtask

    task automatic test_length_limit();
        ack_delay = 0;
        do_reset();
        send_byte(8'h01, 1'b1); send_byte(8'h01, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++; if (fehler !== 1'b1 || cpurst !== 1'b1) begin n_err++;
            $display("FAIL len_257: got fehler=%b cpurst=%b required 1/1", fehler, cpurst); end
        do_reset();
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++; if ({fehler, fertig, init} !== 3'b001) begin n_err++;
            $display("FAIL len_256: got fehler/fertig/init=%b required 001", {fehler, fertig, init}); end
    endtask

    task automatic test_glitch();
        bit ok;
        logic [31:0] w;
        w = $urandom;
        ack_delay = 2;
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_word(w);
        wait_status(200, ok);
        n_cmp++; if (!ok || fertig !== 1'b1 || fehler !== 1'b0) begin n_err++;
            $display("FAIL glitch_status: got fertig=%b fehler=%b required 1/0", fertig, fehler); end
        n_cmp++; if (wr_adr.size() != 1 || wr_dat[0] !== w) begin n_err++;
            $display("FAIL glitch_write: got writes=%0d required 1 with %h", wr_adr.size(), w); end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        logic [31:0] words[4];
        logic [7:0] strm[$];
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 4);
            ack_delay = $urandom_range(0, 30);
            do_reset();
            strm.delete();
            strm.push_back(8'(n % 256));
            strm.push_back(8'(n / 256));
            for (int i = 0; i < n; i++) begin
                words[i] = $urandom;
                for (int k = 0; k < 4; k++) strm.push_back(8'((words[i] >> (8 * k)) & 32'hFF));
            end
            foreach (strm[j]) begin
                if ($urandom_range(0, 3) == 0) begin
                    rx = 1'b0; @(negedge clk); rx = 1'b1;
                    repeat (35) @(negedge clk);
                end else begin
                    repeat ($urandom_range(0, 10)) @(negedge clk);
                end
                send_byte(strm[j], 1'b1);
            end
            wait_status(300, ok);
            n_cmp++; if (!ok || fertig !== 1'b1 || fehler !== 1'b0) begin n_err++;
                $display("FAIL rand%0d_status: got fertig=%b fehler=%b required 1/0", it, fertig, fehler); end
            n_cmp++; if (wr_adr.size() != n || adresse !== 32'(n) || stab_err != 0) begin n_err++;
                $display("FAIL rand%0d_count: got writes=%0d adr=%0d unstable=%0d required %0d/%0d/0",
                         it, wr_adr.size(), adresse, stab_err, n, n); end
            else begin
                for (int i = 0; i < n; i++) begin
                    n_cmp++; if (wr_adr[i] !== 32'(i) || wr_dat[i] !== words[i]) begin n_err++;
                        $display("FAIL rand%0d_w%0d: got (%h,%h) required (%h,%h)", it, i, wr_adr[i], wr_dat[i], 32'(i), words[i]); end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_image();
        test_zero_len();
        test_framing();
        test_overflow();
        test_length_limit();
        test_glitch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
